// File: rtl/rtc_pkg.sv
// Shared constants and BCD helpers for the RTC field bank.
// Default map: year, month, day, hour, min, sec, then three countdown timers.
package rtc_pkg;

  localparam logic [7:0] BCD_9  = 8'h09;
  localparam logic [7:0] BCD_23 = 8'h23;
  localparam logic [7:0] BCD_31 = 8'h31;
  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_99 = 8'h99;

  localparam int NF_DEF = 9;

  localparam logic [8*NF_DEF-1:0] ADDR_MAP_DEF = {
    8'h41, 8'h42, 8'h43, 8'h21, 8'h22,
    8'h23, 8'h24, 8'h25, 8'h26
  };
  localparam logic [8*NF_DEF-1:0] MAX_MAP_DEF = {
    BCD_59, BCD_59, BCD_23, BCD_59, BCD_59,
    BCD_23, BCD_31, 8'h12, BCD_99
  };
  localparam logic [8*NF_DEF-1:0] MIN_MAP_DEF = {
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h01, 8'h01, 8'h00
  };
  localparam logic [NF_DEF-1:0] CPL_MASK_DEF = 9'b111000000;

  typedef enum logic [7:0] {
    CTRL_A0 = 8'h00,
    CTRL_A1 = 8'h01,
    CTRL_A2 = 8'h02
  } ctrl_addr_e;

  function automatic logic [6:0] bcd2bin(input logic [7:0] b);
    return ({3'd0, b[7:4]} * 7'd10) + {3'd0, b[3:0]};
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  function automatic logic bcd_ok(input logic [7:0] b);
    return (b[7:4] <= BCD_9[3:0]) && (b[3:0] <= BCD_9[3:0]);
  endfunction

endpackage

// File: rtl/rtc_bcd_field.sv
// One BCD field: wrap-around edit, range-checked capture,
// complemented storage for countdown timers, and a dirty bit.
module rtc_bcd_field
  import rtc_pkg::*;
#(
  parameter logic [7:0] MAX = 8'h59,
  parameter logic [7:0] MIN = 8'h00,
  parameter bit         CPL = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       cap_i,
  input  logic [7:0] raw_i,
  input  logic       clr_i,
  output logic [7:0] val_o,
  output logic [7:0] wdat_o,
  output logic       dirty_o,
  output logic       err_o
);

  localparam logic [6:0] MAX_B = bcd2bin(MAX);

  logic [7:0] val_q, val_d;
  logic       dirty_q, dirty_d;
  logic       err_q, err_d;
  logic [6:0] val_b;
  logic [7:0] cap_v;
  logic       bad;

  assign val_b = bcd2bin(val_q);
  assign cap_v = CPL ? bin2bcd(MAX_B - bcd2bin(raw_i)) : raw_i;

  // Raw above MAX would underflow the timer complement
  assign bad = !bcd_ok(raw_i)
            || (CPL && (raw_i > MAX))
            || (cap_v > MAX)
            || (cap_v < MIN);

  always_comb begin
    val_d   = val_q;
    dirty_d = clr_i ? 1'b0 : dirty_q;
    err_d   = 1'b0;
    if (inc_i) begin
      val_d   = (val_q == MAX) ? MIN : bin2bcd(val_b + 7'd1);
      dirty_d = 1'b1;
    end else if (dec_i) begin
      val_d   = (val_q == MIN) ? MAX : bin2bcd(val_b - 7'd1);
      dirty_d = 1'b1;
    end else if (cap_i && !dirty_q) begin
      val_d = bad ? MIN : cap_v;
      err_d = bad;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      val_q   <= MIN;
      dirty_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      val_q   <= val_d;
      dirty_q <= dirty_d;
      err_q   <= err_d;
    end
  end

  assign val_o   = val_q;
  assign wdat_o  = CPL ? bin2bcd(MAX_B - val_b) : val_q;
  assign dirty_o = dirty_q;
  assign err_o   = err_q;

endmodule

// File: rtl/rtc_field_bank.sv
// FPGA-side mirror of the RTC register file; owns the shared RTC bus.
// Button sync, address decode, write-data register and tri-state.
module rtc_field_bank
  import rtc_pkg::*;
#(
  parameter int                    NFIELDS  = NF_DEF,
  parameter int                    IW       = 4,
  parameter logic [8*NFIELDS-1:0]  ADDR_MAP = ADDR_MAP_DEF,
  parameter logic [8*NFIELDS-1:0]  MAX_MAP  = MAX_MAP_DEF,
  parameter logic [8*NFIELDS-1:0]  MIN_MAP  = MIN_MAP_DEF,
  parameter logic [NFIELDS-1:0]    CPL_MASK = CPL_MASK_DEF
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   up,
  input  logic                   down,
  input  logic                   sel_valid,
  input  logic [IW-1:0]          sel_idx,
  input  logic [7:0]             bus_addr,
  input  logic                   rd_stb,
  input  logic                   wr_addr_en,
  input  logic                   wr_data_en,
  input  logic [7:0]             ctrl_data,
  inout  wire  [7:0]             rtc_bus,
  output logic [8*NFIELDS-1:0]   fields_o,
  output logic [NFIELDS-1:0]     dirty_o,
  output logic                   range_err_o
);

  localparam logic [IW:0] NF_W = NFIELDS[IW:0];

  logic [2:0] up_q, dn_q;
  logic       wr_q;
  logic [7:0] wd_q, wd_d;
  logic       up_p, dn_p, step_ok, wr_fall;

  logic [NFIELDS-1:0] hit;
  logic [NFIELDS-1:0] err_v;
  logic [7:0]         wdat [NFIELDS];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      up_q <= 3'b000;
      dn_q <= 3'b000;
      wr_q <= 1'b0;
      wd_q <= 8'hFF;
    end else begin
      up_q <= {up_q[1:0], up};
      dn_q <= {dn_q[1:0], down};
      wr_q <= wr_data_en;
      wd_q <= wd_d;
    end
  end

  assign up_p    = up_q[1] & ~up_q[2];
  assign dn_p    = dn_q[1] & ~dn_q[2];
  assign step_ok = sel_valid && ({1'b0, sel_idx} < NF_W);
  assign wr_fall = wr_q & ~wr_data_en;

  for (genvar i = 0; i < NFIELDS; i++) begin : g_fld
    logic sel_hit;
    logic [7:0] val;

    assign hit[i]  = (bus_addr == ADDR_MAP[8*i +: 8]);
    assign sel_hit = step_ok && (sel_idx == IW'(i));

    rtc_bcd_field #(
      .MAX (MAX_MAP[8*i +: 8]),
      .MIN (MIN_MAP[8*i +: 8]),
      .CPL (CPL_MASK[i])
    ) u_fld (
      .CLK     (CLK),
      .RST     (RST),
      .inc_i   (sel_hit & up_p & ~dn_p),
      .dec_i   (sel_hit & dn_p & ~up_p),
      .cap_i   (rd_stb & hit[i]),
      .raw_i   (rtc_bus),
      .clr_i   (wr_fall & hit[i]),
      .val_o   (val),
      .wdat_o  (wdat[i]),
      .dirty_o (dirty_o[i]),
      .err_o   (err_v[i])
    );

    assign fields_o[8*i +: 8] = val;
  end

  // Lowest-numbered field wins if the map ever aliases an address
  always_comb begin
    wd_d = ctrl_data;
    for (int i = NFIELDS - 1; i >= 0; i--) begin
      if (hit[i]) wd_d = wdat[i];
    end
  end

  assign range_err_o = |err_v;

  assign rtc_bus = RST        ? 8'hzz    :
                   wr_addr_en ? bus_addr :
                   wr_data_en ? wd_q     : 8'hzz;

endmodule

// File: tb/tb_rtc_field_bank.sv
// Scoreboard bench for rtc_field_bank: stimulus queues timed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_rtc_field_bank;

  localparam int NF = 9;

  localparam int K_FLD = 0;
  localparam int K_DRT = 1;
  localparam int K_ERR = 2;
  localparam int K_BUS = 3;
  localparam int K_DV  = 4;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            up = 1'b0, down = 1'b0;
  logic            sel_valid = 1'b0;
  logic [3:0]      sel_idx = 4'd0;
  logic [7:0]      bus_addr = 8'h00;
  logic            rd_stb = 1'b0;
  logic            wr_addr_en = 1'b0;
  logic            wr_data_en = 1'b0;
  logic [7:0]      ctrl_data = 8'h00;
  wire  [7:0]      rtc_bus;
  logic [8*NF-1:0] fields_o;
  logic [NF-1:0]   dirty_o;
  logic            range_err_o;

  logic            tb_oe = 1'b0;
  logic [7:0]      tb_dat = 8'h00;

  assign rtc_bus = tb_oe ? tb_dat : 8'hzz;

  rtc_field_bank dut (
    .CLK         (CLK),
    .RST         (RST),
    .up          (up),
    .down        (down),
    .sel_valid   (sel_valid),
    .sel_idx     (sel_idx),
    .bus_addr    (bus_addr),
    .rd_stb      (rd_stb),
    .wr_addr_en  (wr_addr_en),
    .wr_data_en  (wr_data_en),
    .ctrl_data   (ctrl_data),
    .rtc_bus     (rtc_bus),
    .fields_o    (fields_o),
    .dirty_o     (dirty_o),
    .range_err_o (range_err_o)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          cy;
    int          kind;
    int          idx;
    logic [15:0] exp;
    string       nm;
  } chk_t;

  chk_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic push(int cy, int kind, int idx, logic [15:0] e, string nm);
    chk_t c;
    c.cy = cy; c.kind = kind; c.idx = idx; c.exp = e; c.nm = nm;
    q.push_back(c);
  endtask

  function automatic logic [15:0] actual(int kind, int idx);
    case (kind)
      K_FLD:   return {8'h00, fields_o[idx*8 +: 8]};
      K_DRT:   return {15'h0, dirty_o[idx]};
      K_ERR:   return {15'h0, range_err_o};
      K_BUS:   return {8'h00, rtc_bus};
      default: return {7'h0, dirty_o};
    endcase
  endfunction

  always @(negedge CLK) begin
    int i;
    logic [15:0] a;
    i = 0;
    while (i < q.size()) begin
      if (q[i].cy <= cyc) begin
        a = actual(q[i].kind, q[i].idx);
        checks++;
        if (a !== q[i].exp) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%h expected=%h",
                   q[i].nm, cyc, a, q[i].exp);
        end
        q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic press(bit u, bit d, logic [3:0] sel, int ci,
                       logic [7:0] ov, logic [7:0] nv, string nm);
    int e;
    e = cyc;
    sel_valid = 1'b1;
    sel_idx = sel;
    up = u;
    down = d;
    push(e + 2, K_FLD, ci, {8'h00, ov}, {nm, "_before"});
    push(e + 3, K_FLD, ci, {8'h00, nv}, {nm, "_after"});
    push(e + 5, K_FLD, ci, {8'h00, nv}, {nm, "_hold"});
    tick(3);
    up = 1'b0;
    down = 1'b0;
    tick(3);
  endtask

  task automatic cap(logic [7:0] addr, logic [7:0] raw, int fi,
                     logic [7:0] ev, bit err, string nm);
    int e;
    e = cyc;
    bus_addr = addr;
    tb_dat = raw;
    tb_oe = 1'b1;
    rd_stb = 1'b1;
    push(e + 1, K_FLD, fi, {8'h00, ev}, nm);
    push(e + 1, K_ERR, 0, {15'h0, err}, {nm, "_err"});
    push(e + 2, K_ERR, 0, 16'h0, {nm, "_errclr"});
    tick(1);
    rd_stb = 1'b0;
    tb_oe = 1'b0;
    tick(1);
  endtask

  initial begin
    int e;
    tick(2);
    RST = 1'b0;
    tb_oe = 1'b1;
    tb_dat = 8'hA5;
    checks++;
    if (fields_o[8*2 +: 8] !== 8'h01) begin
      failures++;
      $display("FAIL d_rst_day got=%h", fields_o[8*2 +: 8]);
    end
    checks++;
    if (fields_o[7:0] !== 8'h00) begin
      failures++;
      $display("FAIL d_rst_year got=%h", fields_o[7:0]);
    end
    checks++;
    if (dirty_o !== '0) begin
      failures++;
      $display("FAIL d_rst_dirty got=%h", dirty_o);
    end
    checks++;
    if (range_err_o !== 1'b0) begin
      failures++;
      $display("FAIL d_rst_err got=%b", range_err_o);
    end
    push(cyc, K_FLD, 2, 16'h01, "rst_day");
    push(cyc, K_FLD, 0, 16'h00, "rst_year");
    push(cyc, K_FLD, 1, 16'h01, "rst_month");
    push(cyc, K_DV,  0, 16'h000, "rst_dirty");
    push(cyc, K_ERR, 0, 16'h0, "rst_err");
    push(cyc, K_BUS, 0, 16'hA5, "rst_bus_z");
    tick(1);
    tb_oe = 1'b0;

    press(0, 1, 4'd3, 3, 8'h00, 8'h23, "hour_dn_wrap");
    press(1, 0, 4'd3, 3, 8'h23, 8'h00, "hour_up_wrap");
    push(cyc, K_DRT, 3, 16'h1, "hour_dirty");
    press(0, 1, 4'd3, 3, 8'h00, 8'h23, "hour_dn");

    cap(8'h43, 8'h20, 6, 8'h03, 1'b0, "cap_t0_cpl");
    push(cyc, K_DRT, 6, 16'h0, "t0_clean");
    press(1, 0, 4'd6, 6, 8'h03, 8'h04, "t0_up");

    e = cyc;
    bus_addr = 8'h43;
    wr_addr_en = 1'b1;
    push(e, K_BUS, 0, 16'h43, "wr_addr_phase");
    push(e, K_DRT, 6, 16'h1, "t0_dirty");
    tick(1);
    wr_addr_en = 1'b0;
    wr_data_en = 1'b1;
    push(e + 1, K_BUS, 0, 16'h19, "wr_data_cpl");
    tick(1);
    wr_data_en = 1'b0;
    push(e + 2, K_DRT, 6, 16'h1, "t0_dirty_hold");
    push(e + 3, K_DRT, 6, 16'h0, "t0_dirty_clr");
    tick(2);

    press(1, 0, 4'd4, 4, 8'h00, 8'h01, "min_up");
    cap(8'h22, 8'h45, 4, 8'h01, 1'b0, "cap_dirty_drop");
    cap(8'h21, 8'h37, 5, 8'h37, 1'b0, "cap_sec");
    cap(8'h21, 8'h7A, 5, 8'h00, 1'b1, "cap_sec_badnib");
    cap(8'h24, 8'h15, 2, 8'h15, 1'b0, "cap_day");
    cap(8'h24, 8'h32, 2, 8'h01, 1'b1, "cap_day_over");
    cap(8'h41, 8'h00, 8, 8'h59, 1'b0, "cap_t2_full");
    cap(8'h41, 8'h60, 8, 8'h00, 1'b1, "cap_t2_under");
    cap(8'hFE, 8'h12, 8, 8'h00, 1'b0, "cap_unmapped");

    cap(8'h42, 8'h50, 7, 8'h09, 1'b0, "cap_t1");
    press(1, 0, 4'd7, 7, 8'h09, 8'h10, "t1_carry");
    press(0, 1, 4'd7, 7, 8'h10, 8'h09, "t1_borrow");

    press(1, 1, 4'd1, 1, 8'h01, 8'h01, "both_btn");
    push(cyc, K_DV, 0, 16'h098, "dirty_vec_a");
    press(1, 0, 4'd9, 0, 8'h00, 8'h00, "sel_oob");
    push(cyc, K_DV, 0, 16'h098, "dirty_vec_b");

    e = cyc;
    sel_valid = 1'b1;
    sel_idx = 4'd0;
    up = 1'b1;
    tick(2);
    bus_addr = 8'h26;
    tb_dat = 8'h50;
    tb_oe = 1'b1;
    rd_stb = 1'b1;
    push(e + 3, K_FLD, 0, 16'h01, "edit_beats_cap");
    push(e + 3, K_DV, 0, 16'h099, "edit_cap_dirty");
    tick(1);
    rd_stb = 1'b0;
    tb_oe = 1'b0;
    up = 1'b0;
    tick(3);

    e = cyc;
    bus_addr = 8'h01;
    ctrl_data = 8'h04;
    tick(1);
    wr_addr_en = 1'b1;
    wr_data_en = 1'b1;
    push(e + 1, K_BUS, 0, 16'h01, "bus_addr_prio");
    tick(1);
    wr_addr_en = 1'b0;
    push(e + 2, K_BUS, 0, 16'h04, "bus_ctrl_data");
    tick(1);
    wr_data_en = 1'b0;
    tick(1);

    bus_addr = 8'h43;
    wr_data_en = 1'b1;
    tick(1);
    RST = 1'b1;
    tb_oe = 1'b1;
    tb_dat = 8'hA5;
    push(cyc, K_BUS, 0, 16'hA5, "rst_async_bus");
    push(cyc, K_FLD, 3, 16'h00, "rst_async_hour");
    push(cyc, K_FLD, 2, 16'h01, "rst_async_day");
    push(cyc, K_FLD, 6, 16'h00, "rst_async_t0");
    push(cyc, K_DV, 0, 16'h000, "rst_async_dirty");
    tick(1);
    RST = 1'b0;
    wr_data_en = 1'b0;
    tb_oe = 1'b0;
    tick(3);
    @(negedge CLK);
    #1;

    while (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s never_checked expected=%h", q[0].nm, q[0].exp);
      void'(q.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rtc_field_bank.md
# rtc_field_bank

Parametrised bank of BCD time/date/timer fields that mirrors the RTC register file on the FPGA side. It sits between the RTC read/write sequencer and the VGA display path, and owns the shared 8-bit bidirectional RTC data bus. Field count, address map, value ranges and complemented (countdown) storage are all set by parameters. It adds two things over the fixed 9-field version:
- per-field dirty tracking, so user edits are not overwritten by periodic reads;
- range checking of captured data.

## Interface
Parameters:
- NFIELDS, 9: number of BCD fields.
- IW, 4: width of field index; 2**IW >= NFIELDS.
- ADDR_MAP, {8'h41,8'h42,8'h43,8'h21,8'h22,8'h23,8'h24,8'h25,8'h26}: packed 8*NFIELDS; field i RTC address at [8i+7:8i].
- MAX_MAP, {8'h59,8'h59,8'h23,8'h59,8'h59,8'h23,8'h31,8'h12,8'h99}: BCD maximum per field.
- MIN_MAP, {8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h01,8'h01,8'h00}: BCD minimum per field.
- CPL_MASK, 9'b111000000: bit i set means the RTC holds MAX_i - value for field i (timer fields).

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- up  in  1  raw increment button level.
- down  in  1  raw decrement button level.
- sel_valid  in  1  an edit cursor is active.
- sel_idx  in  IW  field under edit.
- bus_addr  in  8  current RTC register address from the sequencer.
- rd_stb  in  1  sample the bus into the field matching bus_addr.
- wr_addr_en  in  1  drive bus_addr onto the bus.
- wr_data_en  in  1  drive write data onto the bus.
- ctrl_data  in  8  data driven for addresses that match no field.
- rtc_bus  inout  8  RTC data bus.
- fields_o  out  8*NFIELDS  packed field values to the display.
- dirty_o  out  NFIELDS  field edited and not yet written back.
- range_err_o  out  1  one-cycle pulse when a capture was out of range.

## Operation
- Button inputs pass through a 2-FF synchroniser plus an edge register. Pulse = s2 & ~s3, at most one per press.
- Edit step (sel_valid=1, sel_idx < NFIELDS), field f = sel_idx:
  - up pulse: f = (f==MAX_f) ? MIN_f : f+1 in BCD, with carry from the low nibble at 9.
  - down pulse: f = (f==MIN_f) ? MAX_f : f-1 in BCD, with borrow to 9.
  - Both pulses in the same cycle: no change, dirty unchanged.
  - Any applied step sets dirty[f].
  - sel_idx >= NFIELDS: the step is ignored.
- Capture (rd_stb=1, bus_addr == ADDR_f, dirty[f]=0):
  - raw = rtc_bus; v = CPL_f ? MAX_f - raw (BCD subtract) : raw.
  - Either nibble > 9, v > MAX_f or v < MIN_f: field gets MIN_f and range_err_o pulses.
  - dirty[f]=1: the capture is dropped silently.
  - rd_stb with an unmapped address: no effect.
- Write data register: wd <= field match ? (CPL_f ? MAX_f - f : f) : ctrl_data.
- Dirty clear: on the falling edge of wr_data_en, dirty[f] for the field matching bus_addr clears. Clears are detected with a registered copy of wr_data_en.
- Bus drive, in priority order:
  - wr_addr_en: bus_addr.
  - else wr_data_en: wd.
  - else: high-Z.
- Simultaneous events on one field:
  - Edit step and capture: the edit wins, dirty set.
  - Edit step and dirty clear: dirty stays 1.
  - Capture and edit on different fields: both apply.

## Timing
- Reset values: all fields = MIN_f, dirty_o = 0, range_err_o = 0, wd = 8'hFF, synchroniser stages = 0, bus high-Z.
- RST mid-edit or mid-write: everything returns to reset values immediately; the bus releases asynchronously.
- Button latency: up rises before CLK edge k; the field changes at edge k+2 and fields_o is visible after edge k+2.
- Capture latency: rd_stb and rtc_bus sampled at edge k; fields_o updated after edge k. range_err_o is high for the cycle after edge k.
- Write data: wd reflects bus_addr and field state one cycle after they change. The sequencer must hold bus_addr at least 1 cycle before asserting wr_data_en.
- Address phase: combinational from bus_addr, zero cycle latency.
- Dirty clear: the cycle after wr_data_en falls, dirty_o bit is 0 after that edge.

## Structure
- Package rtc_pkg holds:
  - BCD constants for 9, 23, 31, 59, 99;
  - default ADDR_MAP, MAX_MAP, MIN_MAP and CPL_MASK;
  - the control register addresses 8'h00–8'h02.
- Sub-module rtc_bcd_field, one instance per field via generate. It holds:
  - the BCD register;
  - inc/dec with wrap;
  - complement on capture and on write;
  - range check;
  - the dirty bit.
- Top level holds the synchronisers, address decode, wd register and tri-state.

## Test plan
- Reset, then read fields_o: field 2 (day) = 8'h01, field 0 (year) = 8'h00, dirty_o = 0, bus Z.
- sel_idx=3 (hour) = 8'h23, up press: 8'h00 at edge k+2, dirty_o[3]=1; down press: 8'h23.
- bus_addr=8'h43, rtc_bus=8'h20, rd_stb: field 6 = 8'h03. Edit field 6 to 8'h04, wr_data_en with 8'h43: bus = 8'h19; wr_data_en falls, dirty_o[6] clears the next cycle.
- Dirty field 4, rd_stb at 8'h22 with rtc_bus=8'h45: field 4 unchanged. Capture 8'h7A at 8'h21: field 5 = 8'h00 and range_err_o pulses for 1 cycle.
- up and down pressed together: no change. bus_addr=8'h01, ctrl_data=8'h04, wr_data_en: bus = 8'h04.
- RST asserted while wr_data_en=1: bus goes to Z immediately and all fields return to MIN.
